// File: rtl/pc_unit_if.sv
// Decode-side bundle for the fetch program-counter unit: redirect requests in,
// fetch address and exception bookkeeping out.
interface pc_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              stall;
    logic              branch;
    logic              jmp;
    logic              jr;
    logic [15:0]       imm16;
    logic [25:0]       imm26;
    logic [ADDR_W-1:0] rs_val;
    logic              exc;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] npc;
    logic [ADDR_W-1:0] link_addr;
    logic [ADDR_W-1:0] epc;
    logic              in_delay_slot;
    logic              addr_err;

    modport master (
        output stall, branch, jmp, jr, imm16, imm26, rs_val, exc,
        input  pc, npc, link_addr, epc, in_delay_slot, addr_err
    );

    modport slave (
        input  stall, branch, jmp, jr, imm16, imm26, rs_val, exc,
        output pc, npc, link_addr, epc, in_delay_slot, addr_err
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter for the mipslite fetch stage: next-PC selection, stall,
// optional branch-delay-slot sequencing, exception vectoring and EPC capture.
module pc_unit #(
    parameter int unsigned ADDR_W       = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
    parameter int unsigned DELAY_SLOT   = 0
) (
    input  logic        clk,
    input  logic        rst,
    pc_unit_if.slave    bus
);

    typedef enum logic [0:0] {StIdle, StPend} state_e;

    localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_VECTOR);
    localparam logic [ADDR_W-1:0] ExcPc   = ADDR_W'(EXC_VECTOR);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              addr_err_q, addr_err_d;

    logic [ADDR_W-1:0] pc_4, pc_b, pc_j, redir_tgt, npc_c;
    logic              idle, redir_req, misalign_req, exc_now;

    assign pc_4 = pc_q + ADDR_W'(4);
    assign pc_b = pc_4 + {{(ADDR_W-18){bus.imm16[15]}}, bus.imm16, 2'b00};
    assign pc_j = {pc_q[ADDR_W-1:28], bus.imm26, 2'b00};

    // Redirects are only accepted outside a delay slot; a branch in the slot is dropped.
    assign idle         = (state_q == StIdle);
    assign redir_req    = idle && (bus.jr || bus.jmp || bus.branch);
    assign misalign_req = idle && bus.jr && (bus.rs_val[1:0] != 2'b00);
    assign exc_now      = bus.exc || misalign_req;

    always_comb begin
        redir_tgt = pc_b;
        if (bus.jr) begin
            redir_tgt = bus.rs_val;
        end else if (bus.jmp) begin
            redir_tgt = pc_j;
        end
    end

    always_comb begin
        npc_c = pc_4;
        if (exc_now) begin
            npc_c = ExcPc;
        end else if (!idle) begin
            npc_c = pend_tgt_q;
        end else if (redir_req) begin
            npc_c = (DELAY_SLOT != 0) ? pc_4 : redir_tgt;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        pend_tgt_d = pend_tgt_q;
        addr_err_d = 1'b0;
        // exc is honoured through a stall; a misaligned jr is a redirect and waits.
        if (bus.exc || (!bus.stall && misalign_req)) begin
            pc_d       = ExcPc;
            epc_d      = pc_q;
            state_d    = StIdle;
            addr_err_d = !bus.exc;
        end else if (!bus.stall) begin
            pc_d = npc_c;
            if (!idle) begin
                state_d = StIdle;
            end else if (redir_req && (DELAY_SLOT != 0)) begin
                pend_tgt_d = redir_tgt;
                state_d    = StPend;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= ResetPc;
            epc_q      <= '0;
            pend_tgt_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            pend_tgt_q <= pend_tgt_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.npc           = npc_c;
    assign bus.link_addr     = (DELAY_SLOT != 0) ? pc_q + ADDR_W'(8) : pc_4;
    assign bus.epc           = epc_q;
    assign bus.in_delay_slot = (state_q == StPend);
    assign bus.addr_err      = addr_err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: one instance without and one with a delay slot.
module tb_pc_unit;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    pc_unit_if #(.ADDR_W(32)) bus_a ();
    pc_unit_if #(.ADDR_W(32)) bus_b ();

    pc_unit #(.ADDR_W(32), .DELAY_SLOT(0)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    pc_unit #(.ADDR_W(32), .DELAY_SLOT(1)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.stall = 0; bus_a.branch = 0; bus_a.jmp = 0; bus_a.jr = 0;
        bus_a.imm16 = '0; bus_a.imm26 = '0; bus_a.rs_val = '0; bus_a.exc = 0;
    endtask

    task automatic idle_b();
        bus_b.stall = 0; bus_b.branch = 0; bus_b.jmp = 0; bus_b.jr = 0;
        bus_b.imm16 = '0; bus_b.imm26 = '0; bus_b.rs_val = '0; bus_b.exc = 0;
    endtask

    initial begin
        idle_a();
        idle_b();
        rst_a = 1;
        rst_b = 1;
        step();
        rst_a = 0;

        // ---- DELAY_SLOT = 0 ----
        check_eq("a_reset_pc", bus_a.pc, 32'h0);
        check_eq("a_reset_epc", bus_a.epc, 32'h0);
        check_eq("a_reset_aerr", 32'(bus_a.addr_err), 32'h0);
        step(); check_eq("a_seq1", bus_a.pc, 32'h4);
        step(); check_eq("a_seq2", bus_a.pc, 32'h8);
        step(); check_eq("a_seq3", bus_a.pc, 32'hC);
        check_eq("a_link", bus_a.link_addr, 32'h10);
        check_eq("a_ids", 32'(bus_a.in_delay_slot), 32'h0);

        bus_a.jr = 1; bus_a.rs_val = 32'h100; #1;
        check_eq("a_npc_jr", bus_a.npc, 32'h100);
        step(); idle_a();
        check_eq("a_pc_jr", bus_a.pc, 32'h100);

        bus_a.branch = 1; bus_a.imm16 = 16'hFFFE; #1;
        check_eq("a_npc_branch", bus_a.npc, 32'hFC);
        bus_a.jmp = 1; bus_a.imm26 = 26'h0000040; #1;
        check_eq("a_npc_jmp_over_br", bus_a.npc, 32'h100);
        bus_a.exc = 1; #1;
        check_eq("a_npc_exc_prio", bus_a.npc, 32'h180);
        bus_a.exc = 0;
        step(); idle_a();
        check_eq("a_pc_jmp", bus_a.pc, 32'h100);
        bus_a.branch = 1; bus_a.imm16 = 16'hFFFE;
        step(); idle_a();
        check_eq("a_pc_branch", bus_a.pc, 32'hFC);

        bus_a.jr = 1; bus_a.rs_val = 32'h40;
        step();
        check_eq("a_pc_40", bus_a.pc, 32'h40);
        bus_a.rs_val = 32'h402; #1;
        check_eq("a_npc_misalign", bus_a.npc, 32'h180);
        step(); idle_a();
        check_eq("a_misalign_pc", bus_a.pc, 32'h180);
        check_eq("a_misalign_epc", bus_a.epc, 32'h40);
        check_eq("a_misalign_aerr", 32'(bus_a.addr_err), 32'h1);
        step();
        check_eq("a_aerr_drop", 32'(bus_a.addr_err), 32'h0);
        check_eq("a_after_exc_pc", bus_a.pc, 32'h184);

        bus_a.jr = 1; bus_a.rs_val = 32'h20;
        step(); idle_a();
        check_eq("a_pc_20", bus_a.pc, 32'h20);
        bus_a.stall = 1; bus_a.branch = 1; bus_a.imm16 = 16'h0005;
        step(); check_eq("a_stall1", bus_a.pc, 32'h20);
        step(); check_eq("a_stall2", bus_a.pc, 32'h20);
        check_eq("a_stall_epc", bus_a.epc, 32'h40);
        bus_a.exc = 1;
        step(); idle_a();
        check_eq("a_exc_stall_pc", bus_a.pc, 32'h180);
        check_eq("a_exc_stall_epc", bus_a.epc, 32'h20);
        check_eq("a_exc_no_aerr", 32'(bus_a.addr_err), 32'h0);

        // ---- DELAY_SLOT = 1 ----
        rst_b = 1;
        step();
        rst_b = 0;
        check_eq("b_reset_pc", bus_b.pc, 32'h0);
        check_eq("b_reset_ids", 32'(bus_b.in_delay_slot), 32'h0);
        check_eq("b_link", bus_b.link_addr, 32'h8);

        bus_b.jr = 1; bus_b.rs_val = 32'h200;
        step(); idle_b();
        check_eq("b_slot_pc", bus_b.pc, 32'h4);
        check_eq("b_slot_ids", 32'(bus_b.in_delay_slot), 32'h1);
        step();
        check_eq("b_pc_200", bus_b.pc, 32'h200);

        bus_b.jr = 1; bus_b.rs_val = 32'h400;
        step(); idle_b();
        check_eq("b_jr_slot_pc", bus_b.pc, 32'h204);
        check_eq("b_jr_slot_ids", 32'(bus_b.in_delay_slot), 32'h1);
        bus_b.branch = 1; bus_b.imm16 = 16'h0010; #1;
        check_eq("b_npc_pend", bus_b.npc, 32'h400);
        step(); idle_b();
        check_eq("b_jr_tgt_pc", bus_b.pc, 32'h400);
        check_eq("b_jr_tgt_ids", 32'(bus_b.in_delay_slot), 32'h0);

        bus_b.jr = 1; bus_b.rs_val = 32'h10;
        step(); idle_b();
        step();
        check_eq("b_pc_10", bus_b.pc, 32'h10);
        bus_b.jmp = 1; bus_b.imm26 = 26'h0000100;
        step(); idle_b();
        check_eq("b_jmp_slot_pc", bus_b.pc, 32'h14);
        rst_b = 1;
        step();
        rst_b = 0;
        check_eq("b_rst_pend_pc", bus_b.pc, 32'h0);
        check_eq("b_rst_pend_ids", 32'(bus_b.in_delay_slot), 32'h0);
        step();
        check_eq("b_rst_discard", bus_b.pc, 32'h4);

        bus_b.jmp = 1; bus_b.imm26 = 26'h0000100;
        step(); idle_b();
        check_eq("b_jmp2_slot", bus_b.pc, 32'h8);
        bus_b.exc = 1; #1;
        check_eq("b_npc_exc_pend", bus_b.npc, 32'h180);
        step(); idle_b();
        check_eq("b_exc_pend_pc", bus_b.pc, 32'h180);
        check_eq("b_exc_pend_epc", bus_b.epc, 32'h8);
        check_eq("b_exc_pend_ids", 32'(bus_b.in_delay_slot), 32'h0);
        step();
        check_eq("b_exc_discard", bus_b.pc, 32'h184);

        bus_b.jr = 1; bus_b.rs_val = 32'h401;
        step(); idle_b();
        check_eq("b_misalign_pc", bus_b.pc, 32'h180);
        check_eq("b_misalign_ids", 32'(bus_b.in_delay_slot), 32'h0);
        check_eq("b_misalign_aerr", 32'(bus_b.addr_err), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
